// File: rtl/pmpseqcheck_if.sv
// pmpseqcheck_if: request/response handshake and live PMP CSR bundle for pmpseqcheck.
//
// master modport (requester / CSR side):
//   drives ReqValid, PhysicalAddress, Size, AccessType, PrivilegeMode,
//   PMPCfgArray, PMPAdrArray, PMPCSRWrite, Flush, RespReady;
//   observes ReqReady, RespValid, Fault, MatchValid, MatchIdx.
// slave modport (checker side): the mirror image.
interface pmpseqcheck_if #(
    parameter int unsigned NENTRIES = 16,
    parameter int unsigned PaBits   = 34
);
    localparam int unsigned IdxW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;

    logic                           ReqValid;
    logic                           ReqReady;
    logic [PaBits-1:0]              PhysicalAddress;
    logic [1:0]                     Size;
    logic [2:0]                     AccessType;
    logic [1:0]                     PrivilegeMode;
    logic [8*NENTRIES-1:0]          PMPCfgArray;
    logic [(PaBits-2)*NENTRIES-1:0] PMPAdrArray;
    logic                           PMPCSRWrite;
    logic                           Flush;
    logic                           RespValid;
    logic                           RespReady;
    logic                           Fault;
    logic                           MatchValid;
    logic [IdxW-1:0]                MatchIdx;

    modport slave (
        input  ReqValid, PhysicalAddress, Size, AccessType, PrivilegeMode,
               PMPCfgArray, PMPAdrArray, PMPCSRWrite, Flush, RespReady,
        output ReqReady, RespValid, Fault, MatchValid, MatchIdx
    );

    modport master (
        output ReqValid, PhysicalAddress, Size, AccessType, PrivilegeMode,
               PMPCfgArray, PMPAdrArray, PMPCSRWrite, Flush, RespReady,
        input  ReqReady, RespValid, Fault, MatchValid, MatchIdx
    );
endinterface

// File: rtl/pmpseqcheck.sv
// pmpseqcheck: sequential PMP checker. One shared address decoder is stepped across the
// PMP entries, one entry per cycle in priority order (entry 0 first). One request in flight.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-low reset
//   bus    - pmpseqcheck_if.slave: request capture (ReqValid/ReqReady + fields), live PMP
//            cfg/addr arrays, PMPCSRWrite (restarts a scan), Flush (abandons the request),
//            registered result (RespValid/RespReady, Fault, MatchValid, MatchIdx).
// PaBits is the physical address width (the config PA_BITS value).
module pmpseqcheck #(
    parameter int unsigned NENTRIES = 16,
    parameter int unsigned PaBits   = 34
) (
    input logic          clk,
    input logic          reset,
    pmpseqcheck_if.slave bus
);
    localparam int unsigned IdxW = (NENTRIES > 1) ? $clog2(NENTRIES) : 1;
    localparam int unsigned AdrW = PaBits - 2;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NENTRIES - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              ge_q, ge_d, cross_q, cross_d;
    logic              restart_q, restart_d;
    logic [PaBits-1:0] pa_q, pa_d;
    logic [1:0]        size_q, size_d, priv_q, priv_d;
    logic [2:0]        acc_q, acc_d;
    logic              resp_valid_q, resp_valid_d, fault_q, fault_d;
    logic              match_valid_q, match_valid_d;
    logic [IdxW-1:0]   match_idx_q, match_idx_d;

    // ---------------- shared address decoder (entry idx_q) ----------------
    logic [2:0]      cfg_xwr;
    logic [1:0]      cfg_a;
    logic            cfg_l;
    logic [AdrW-1:0] adr, napot_mask, pa_w;
    logic [AdrW:0]   adr_x, end_w;  // end word carries one extra bit for top-of-space overflow
    logic [3:0]      bytes_m1;
    logic [1:0]      word_inc;
    logic            ge_out, cross_out, match, all_match, start_in, end_in, allowed;

    assign cfg_xwr = bus.PMPCfgArray[8*int'(idx_q) +: 3];
    assign cfg_a   = bus.PMPCfgArray[8*int'(idx_q)+3 +: 2];
    assign cfg_l   = bus.PMPCfgArray[8*int'(idx_q)+7];
    assign adr     = bus.PMPAdrArray[AdrW*int'(idx_q) +: AdrW];
    assign adr_x   = {1'b0, adr};

    // Word address of the first and last byte of the access.
    assign pa_w     = pa_q[PaBits-1:2];
    assign bytes_m1 = (4'd1 << size_q) - 4'd1;
    assign word_inc = 2'(({2'b00, pa_q[1:0]} + bytes_m1) >> 2);
    assign end_w    = {1'b0, pa_w} + {{(AdrW-1){1'b0}}, word_inc};

    // Trailing ones plus the next zero bit are the don't-care bits of a NAPOT region.
    assign napot_mask = adr ^ (adr + AdrW'(1));
    assign start_in   = (pa_w & ~napot_mask) == (adr & ~napot_mask);
    assign end_in     = ~end_w[AdrW] & ((end_w[AdrW-1:0] & ~napot_mask) == (adr & ~napot_mask));

    // Chain outputs feed the next entry's TOR bottom bound.
    assign ge_out    = pa_w >= adr;
    assign cross_out = (pa_w < adr) & (end_w >= adr_x);

    always_comb begin
        match     = 1'b0;
        all_match = 1'b0;
        unique case (cfg_a)
            2'd1: begin  // TOR: [prev, adr); cross_q means the access straddles the bottom
                match     = (ge_q | cross_q) & (pa_w < adr);
                all_match = ge_q & (end_w < adr_x);
            end
            2'd2: begin  // NA4
                match     = (pa_w <= adr) & (end_w >= adr_x);
                all_match = (pa_w == adr) & (end_w == adr_x);
            end
            2'd3: begin  // NAPOT: regions are >= 8 bytes and aligned, so endpoints suffice
                match     = start_in | end_in;
                all_match = start_in & end_in;
            end
            default: ;
        endcase
    end

    assign allowed = all_match & (((priv_q == 2'b11) & ~cfg_l) | (|(acc_q & cfg_xwr)));

    // ---------------- control ----------------
    assign bus.ReqReady   = (state_q == StIdle) & reset & ~bus.Flush;
    assign bus.RespValid  = resp_valid_q;
    assign bus.Fault      = fault_q;
    assign bus.MatchValid = match_valid_q;
    assign bus.MatchIdx   = match_idx_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ge_d          = ge_q;
        cross_d       = cross_q;
        restart_d     = 1'b0;
        pa_d          = pa_q;
        size_d        = size_q;
        acc_d         = acc_q;
        priv_d        = priv_q;
        resp_valid_d  = resp_valid_q;
        fault_d       = fault_q;
        match_valid_d = match_valid_q;
        match_idx_d   = match_idx_q;

        unique case (state_q)
            StIdle: begin
                if (bus.ReqValid && bus.ReqReady) begin
                    state_d = StScan;
                    pa_d    = bus.PhysicalAddress;
                    size_d  = bus.Size;
                    acc_d   = bus.AccessType;
                    priv_d  = bus.PrivilegeMode;
                    idx_d   = '0;
                    ge_d    = 1'b1;
                    cross_d = 1'b0;
                end
            end
            StScan: begin
                if (bus.Flush) begin
                    state_d = StIdle;
                end else if (bus.PMPCSRWrite) begin
                    // Discard progress; the cycle after a write is a settle cycle so the
                    // whole rescan sees only post-write CSR values.
                    idx_d     = '0;
                    ge_d      = 1'b1;
                    cross_d   = 1'b0;
                    restart_d = 1'b1;
                end else if (!restart_q) begin
                    ge_d    = ge_out;
                    cross_d = cross_out;
                    idx_d   = (idx_q == LastIdx) ? idx_q : idx_q + IdxW'(1);
                    if (match) begin
                        state_d       = StDone;
                        resp_valid_d  = 1'b1;
                        fault_d       = ~allowed;
                        match_valid_d = 1'b1;
                        match_idx_d   = idx_q;
                    end else if (idx_q == LastIdx) begin
                        state_d       = StDone;
                        resp_valid_d  = 1'b1;
                        fault_d       = priv_q != 2'b11;
                        match_valid_d = 1'b0;
                        match_idx_d   = '0;
                    end
                end
            end
            StDone: begin
                if (bus.Flush || bus.RespReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            resp_valid_d  = 1'b0;
            fault_d       = 1'b0;
            match_valid_d = 1'b0;
            match_idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            ge_q          <= 1'b1;
            cross_q       <= 1'b0;
            restart_q     <= 1'b0;
            pa_q          <= '0;
            size_q        <= '0;
            acc_q         <= '0;
            priv_q        <= '0;
            resp_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
            match_valid_q <= 1'b0;
            match_idx_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ge_q          <= ge_d;
            cross_q       <= cross_d;
            restart_q     <= restart_d;
            pa_q          <= pa_d;
            size_q        <= size_d;
            acc_q         <= acc_d;
            priv_q        <= priv_d;
            resp_valid_q  <= resp_valid_d;
            fault_q       <= fault_d;
            match_valid_q <= match_valid_d;
            match_idx_q   <= match_idx_d;
        end
    end
endmodule

// File: tb/tb_pmpseqcheck.sv
// Directed bench for pmpseqcheck: expected results are queued when a request is issued and
// popped when the checker responds (or when its no-response window closes).
module tb_pmpseqcheck;
    localparam int unsigned N  = 16;
    localparam int unsigned PA = 34;
    localparam int unsigned AW = PA - 2;

    typedef struct {
        int         lat;    // cycles from accept to RespValid; -1 = no response expected
        logic       fault;
        logic       mv;
        logic [3:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pmpseqcheck_if #(.NENTRIES(N), .PaBits(PA)) bus ();

    pmpseqcheck #(.NENTRIES(N), .PaBits(PA)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_all();
        bus.PMPCfgArray = '0;
        bus.PMPAdrArray = '0;
    endtask

    task automatic set_entry(input int i, input logic [7:0] c, input logic [AW-1:0] a);
        bus.PMPCfgArray[8*i +: 8]   = c;
        bus.PMPAdrArray[AW*i +: AW] = a;
    endtask

    // Issue one request at the current negedge (cycle 0). wr_cyc/fl_cyc pulse PMPCSRWrite /
    // Flush in that cycle (0 = never); hold = cycles of RespReady=0 in DONE; flush_done
    // raises Flush together with RespReady when the result is taken.
    task automatic do_req(input string tag, input logic [PA-1:0] pa, input logic [1:0] sz,
                          input logic [2:0] acc, input logic [1:0] priv, input int wr_cyc,
                          input int fl_cyc, input int hold, input bit flush_done,
                          input exp_t e);
        exp_t ex;
        int   cyc;
        bit   got;
        check({tag, ":req_ready"}, 32'(bus.ReqReady), 32'd1);
        bus.ReqValid        = 1'b1;
        bus.PhysicalAddress = pa;
        bus.Size            = sz;
        bus.AccessType      = acc;
        bus.PrivilegeMode   = priv;
        sb.push_back(e);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 30) begin
            step();
            cyc++;
            if (bus.RespValid === 1'b1) got = 1'b1;
            bus.ReqValid    = 1'b0;
            bus.PMPCSRWrite = (cyc == wr_cyc);
            bus.Flush       = (cyc == fl_cyc);
            if (fl_cyc != 0 && cyc == fl_cyc + 1) begin
                #1;
                check({tag, ":ready_after_flush"}, 32'(bus.ReqReady), 32'd1);
            end
        end
        bus.PMPCSRWrite = 1'b0;
        bus.Flush       = 1'b0;
        ex = sb.pop_front();
        if (ex.lat < 0) begin
            check({tag, ":no_resp"}, 32'(got), 32'd0);
        end else begin
            check({tag, ":latency"}, got ? cyc : -1, ex.lat);
            check({tag, ":fault"}, 32'(bus.Fault), 32'(ex.fault));
            check({tag, ":match_valid"}, 32'(bus.MatchValid), 32'(ex.mv));
            check({tag, ":match_idx"}, 32'(bus.MatchIdx), 32'(ex.idx));
            for (int i = 0; i < hold; i++) begin
                step();
                check({tag, ":hold_valid"}, 32'(bus.RespValid), 32'd1);
                check({tag, ":hold_fault"}, 32'(bus.Fault), 32'(ex.fault));
                check({tag, ":hold_idx"}, 32'(bus.MatchIdx), 32'(ex.idx));
            end
            bus.RespReady = 1'b1;
            bus.Flush     = flush_done;
            step();
            bus.RespReady = 1'b0;
            bus.Flush     = 1'b0;
            #1;
            check({tag, ":released"}, 32'(bus.RespValid), 32'd0);
            check({tag, ":idle_ready"}, 32'(bus.ReqReady), 32'd1);
        end
    endtask

    initial begin
        reset               = 1'b0;
        bus.ReqValid        = 1'b1;
        bus.PhysicalAddress = '0;
        bus.Size            = '0;
        bus.AccessType      = '0;
        bus.PrivilegeMode   = '0;
        bus.PMPCSRWrite     = 1'b0;
        bus.Flush           = 1'b0;
        bus.RespReady       = 1'b0;
        clear_all();

        // 1. Reset holds everything quiet even with a request pending.
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst:ready", 32'(bus.ReqReady), 32'd0);
            check("rst:resp_valid", 32'(bus.RespValid), 32'd0);
        end
        check("rst:fault", 32'(bus.Fault), 32'd0);
        check("rst:match_valid", 32'(bus.MatchValid), 32'd0);
        check("rst:match_idx", 32'(bus.MatchIdx), 32'd0);
        bus.ReqValid = 1'b0;
        reset        = 1'b1;
        step();
        check("rst:ready_after_release", 32'(bus.ReqReady), 32'd1);

        // Flush in IDLE blocks acceptance.
        bus.ReqValid = 1'b1;
        bus.Flush    = 1'b1;
        #1;
        check("idle_flush:ready", 32'(bus.ReqReady), 32'd0);
        step();
        bus.ReqValid = 1'b0;
        bus.Flush    = 1'b0;
        step();
        check("idle_flush:no_resp", 32'(bus.RespValid), 32'd0);

        // 2. NAPOT 0x10000-0x10FFF RW at entry 3; also exercises 5 cycles of backpressure.
        clear_all();
        set_entry(3, 8'h1B, 32'h41FF);
        do_req("napot_read", 34'h10ABC, 2'd2, 3'b001, 2'b00, 0, 0, 5, 1'b0,
               '{5, 1'b0, 1'b1, 4'd3});
        do_req("napot_exec", 34'h10ABC, 2'd2, 3'b100, 2'b00, 0, 0, 0, 1'b0,
               '{5, 1'b1, 1'b1, 4'd3});

        // 3. NA4 at 0x400: an 8-byte access straddles it and faults even in M-mode.
        clear_all();
        set_entry(2, 8'h13, 32'h100);
        do_req("na4_partial", 34'h400, 2'd3, 3'b001, 2'b11, 0, 0, 0, 1'b0,
               '{4, 1'b1, 1'b1, 4'd2});
        do_req("na4_full", 34'h400, 2'd2, 3'b001, 2'b11, 0, 0, 0, 1'b0,
               '{4, 1'b0, 1'b1, 4'd2});

        // 4. No match: full scan, fault only outside M-mode.
        clear_all();
        do_req("nomatch_u", 34'h50000, 2'd2, 3'b001, 2'b00, 0, 0, 0, 1'b0,
               '{17, 1'b1, 1'b0, 4'd0});
        do_req("nomatch_m", 34'h50000, 2'd2, 3'b001, 2'b11, 0, 0, 0, 1'b0,
               '{17, 1'b0, 1'b0, 4'd0});

        // 5. Restart on CSR write, flush mid-scan, flush with RespReady in DONE.
        set_entry(3, 8'h1B, 32'h41FF);
        do_req("restart", 34'h10ABC, 2'd2, 3'b001, 2'b00, 2, 0, 0, 1'b0,
               '{8, 1'b0, 1'b1, 4'd3});
        do_req("flush_scan", 34'h10ABC, 2'd2, 3'b001, 2'b00, 0, 3, 0, 1'b0,
               '{-1, 1'b0, 1'b0, 4'd0});
        do_req("flush_done", 34'h10ABC, 2'd2, 3'b001, 2'b00, 0, 0, 0, 1'b1,
               '{5, 1'b0, 1'b1, 4'd3});

        // 6. Reset during SCAN drops the request.
        bus.ReqValid        = 1'b1;
        bus.PhysicalAddress = 34'h10ABC;
        bus.Size            = 2'd2;
        bus.AccessType      = 3'b001;
        bus.PrivilegeMode   = 2'b00;
        sb.push_back('{-1, 1'b0, 1'b0, 4'd0});
        step();
        bus.ReqValid = 1'b0;
        step();
        reset = 1'b0;
        step();
        check("scan_rst:resp_valid", 32'(bus.RespValid), 32'd0);
        check("scan_rst:fault", 32'(bus.Fault), 32'd0);
        check("scan_rst:match_valid", 32'(bus.MatchValid), 32'd0);
        check("scan_rst:ready", 32'(bus.ReqReady), 32'd0);
        reset = 1'b1;
        begin
            int seen;
            exp_t ex;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (bus.RespValid !== 1'b0) seen++;
            end
            ex = sb.pop_front();
            check("scan_rst:stale_resp", seen, (ex.lat < 0) ? 0 : 1);
        end
        check("scan_rst:ready_after", 32'(bus.ReqReady), 32'd1);

        // Minimum latency: TOR [0, 0x400) R-only at entry 0.
        clear_all();
        set_entry(0, 8'h09, 32'h100);
        do_req("tor_read", 34'h200, 2'd2, 3'b001, 2'b00, 0, 0, 0, 1'b0,
               '{2, 1'b0, 1'b1, 4'd0});
        do_req("tor_write", 34'h200, 2'd2, 3'b010, 2'b00, 0, 0, 0, 1'b0,
               '{2, 1'b1, 1'b1, 4'd0});

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pmpseqcheck.md
# pmpseqcheck

Sequential PMP checker that time-multiplexes one `pmpadrdec` instance across all PMP entries, scanning one entry per cycle in priority order (entry 0 first). It sits between the MMU request path and the PMP CSR array. It is used where area matters more than latency, for example page-table-walker and DMA ports. It accepts one request at a time, returns fault/allow plus the matching entry index, and restarts the scan if the PMP CSRs are written mid-scan.

## Interface
- NENTRIES, 16, number of PMP entries scanned (1–64); `PA_BITS` comes from the config header.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  block can accept; high only in IDLE and while reset is high.
- PhysicalAddress  in  `PA_BITS`  access address, captured at accept.
- Size  in  2  log2 of access bytes, captured at accept.
- AccessType  in  3  one-hot {Execute, Write, Read}, captured at accept.
- PrivilegeMode  in  2  2'b11 = M, captured at accept.
- PMPCfgArray  in  8*NENTRIES  live cfg bytes; entry i is at [8i+7:8i].
- PMPAdrArray  in  (`PA_BITS`-2)*NENTRIES  live pmpaddr values.
- PMPCSRWrite  in  1  any pmpcfg/pmpaddr write this cycle.
- Flush  in  1  abandon the in-flight request.
- RespValid  out  1  result valid.
- RespReady  in  1  consumer takes the result.
- Fault  out  1  access denied.
- MatchValid  out  1  some entry matched.
- MatchIdx  out  $clog2(NENTRIES) (min 1)  lowest matching entry.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE → SCAN on ReqValid & ReqReady.
  - Captures the request fields.
  - Sets idx=0, GePrev=1, CrossPrev=0.
- SCAN evaluates entry idx through the shared decoder.
  - Inputs: PAgePMPAdrIn=GePrev, TORCrossPrevIn=CrossPrev.
  - Each cycle: GePrev←PAgePMPAdrOut, CrossPrev←TORCrossPrevOut, idx←idx+1.
- SCAN → DONE when Match is high, or after idx=NENTRIES−1 with no match.
  - idx saturates and never wraps.
- Result on a match at entry k: MatchValid=1, MatchIdx=k.
  - Allowed = AllBytesMatch & ((PrivilegeMode==M & ~L) | (AccessType & {X,W,R}) != 0).
  - Fault = ~Allowed. A partial match faults even in M-mode.
- Result with no match: MatchValid=0, MatchIdx=0, Fault = (PrivilegeMode != M).
- DONE holds all result outputs stable until RespReady, then goes to IDLE. No new request is accepted in the same cycle.
- PMPCSRWrite high in SCAN restarts the scan:
  - idx=0, GePrev=1, CrossPrev=0 next cycle.
  - The result is never formed from mixed configurations.
  - PMPCSRWrite in IDLE or DONE has no effect; a result already in DONE stands.
- Flush high in SCAN or DONE returns to IDLE next cycle with RespValid=0 and no response.
  - Flush beats RespReady and PMPCSRWrite in the same cycle.
  - Flush in IDLE blocks acceptance that cycle.
- Reset low in any state:
  - Next state is IDLE; idx=0; all response outputs are 0.
  - ReqReady=0 while reset is low.
  - An in-flight request is dropped.

## Timing
- Reset values: RespValid=0, Fault=0, MatchValid=0, MatchIdx=0, state=IDLE. ReqReady goes to 1 the first cycle after reset is released.
- Outputs are registered. ReqReady is decoded from state.
- Accept in cycle 0 means entry 0 is evaluated in cycle 1.
- A match at entry k gives RespValid in cycle k+2. Minimum latency is 2; no-match latency is NENTRIES+1.
- Each restart adds (cycles already scanned + 1).
- Throughput is one request per (latency + 1) cycles, because IDLE is revisited between requests.
- Live cfg/adr values are sampled in the cycle each entry is evaluated. Stability between writes is guaranteed by the PMPCSRWrite restart.

## Test plan
Setup for all scenarios: NENTRIES=16, all entries OFF except as stated.

1. Reset and idle handshake:
   - Hold reset low for 3 cycles with ReqValid=1 → ReqReady=0 and RespValid=0 throughout.
   - Cycle after release → ReqReady=1.
2. NAPOT match:
   - Entry 3 has adr=0x41FF and cfg=0x1B, giving PA range 0x10000–0x10FFF with R and W.
   - U-mode read of PA 0x10ABC accepted in cycle 0 → RespValid in cycle 5, MatchValid=1, MatchIdx=3, Fault=0.
   - Same access as execute → Fault=1.
3. NA4 partial match:
   - Entry 2 has adr=0x100 and cfg=0x13.
   - M-mode Size=3 read of PA 0x400 → MatchIdx=2, Fault=1 due to the boundary cross.
   - Size=2 read of the same PA → Fault=0.
4. No match:
   - U-mode read of PA 0x50000 → RespValid in cycle 17, MatchValid=0, Fault=1.
   - Same access in M-mode → Fault=0.
5. Restart and flush:
   - Scenario 2 with PMPCSRWrite pulsed in cycle 2 → RespValid in cycle 8.
   - Scenario 2 with Flush in cycle 3 → no RespValid ever, ReqReady=1 in cycle 4.
   - Flush together with RespReady in DONE → response dropped.
6. Backpressure and mid-scan reset:
   - Hold RespReady=0 for 5 cycles in DONE → outputs unchanged.
   - Assert RespReady → IDLE next cycle.
   - Reset low during SCAN → all outputs 0 next cycle, no stale response.
